// File: rtl/hit_judge_multi.sv
// Reaction-game hit/miss judge: lights a random target pattern on freq, judges the first
// switch activity inside the response window, keeps saturating scores and a game-over lock.
module hit_judge_multi #(
    parameter int unsigned N_LANES       = 8,
    parameter int unsigned WINDOW_CYCLES = 100000000,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned MAX_MISSES    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freq,
    input  logic [N_LANES-1:0] random,
    input  logic [N_LANES-1:0] switch,
    output logic [N_LANES-1:0] led,
    output logic               busy,
    output logic               hit,
    output logic               miss,
    output logic               timeout,
    output logic [SCORE_W-1:0] hit_count,
    output logic [SCORE_W-1:0] miss_count,
    output logic               game_over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        OVER   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MISS_LIM  = SCORE_W'(MAX_MISSES);
    localparam bit                 LIM_EN    = (MAX_MISSES != 0);

    state_t             r_state;
    logic [N_LANES-1:0] r_switch_mem;
    logic [N_LANES-1:0] r_target;
    logic [CNT_W-1:0]   r_counter;

    logic [N_LANES-1:0] w_changed;
    logic [SCORE_W-1:0] w_hit_inc;
    logic [SCORE_W-1:0] w_miss_inc;
    logic               w_reach_limit;

    assign w_changed     = switch ^ r_switch_mem;
    assign w_hit_inc     = (hit_count == '1)  ? hit_count  : hit_count + SCORE_W'(1);
    assign w_miss_inc    = (miss_count == '1) ? miss_count : miss_count + SCORE_W'(1);
    assign w_reach_limit = LIM_EN && (w_miss_inc == MISS_LIM);

    always_ff @(posedge clk) begin
        r_switch_mem <= switch;
        if (rst) begin
            r_state    <= IDLE;
            r_target   <= '0;
            r_counter  <= '0;
            led        <= '0;
            busy       <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            timeout    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            game_over  <= 1'b0;
        end else begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (freq && (random != '0)) begin
                        r_target  <= random;
                        r_counter <= '0;
                        led       <= random;
                        busy      <= 1'b1;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Switch activity takes priority over the window expiring on the same edge
                    if ((w_changed != '0) && (w_changed == r_target)) begin
                        hit       <= 1'b1;
                        hit_count <= w_hit_inc;
                        led       <= '0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end else if ((w_changed != '0) || (r_counter == LAST_CNT)) begin
                        miss       <= 1'b1;
                        timeout    <= (w_changed == '0);
                        miss_count <= w_miss_inc;
                        busy       <= 1'b0;
                        if (w_reach_limit) begin
                            led       <= '1;
                            game_over <= 1'b1;
                            r_state   <= OVER;
                        end else begin
                            led     <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_counter <= r_counter + CNT_W'(1);
                    end
                end
                OVER: begin
                    led       <= '1;
                    busy      <= 1'b0;
                    game_over <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_judge_multi.sv
// Scoreboard bench for hit_judge_multi: rounds are modelled at the game level (outcome,
// judging edge, scores) and a monitor checks every pulse the DUT emits against the queue.
module tb_hit_judge_multi;

    localparam int unsigned NL = 8;
    localparam int unsigned WC = 16;
    localparam int unsigned SW = 8;
    localparam int unsigned MM = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          freq;
    logic [NL-1:0] random;
    logic [NL-1:0] switch;
    logic [NL-1:0] led;
    logic          busy, hit, miss, timeout, game_over;
    logic [SW-1:0] hit_count, miss_count;

    hit_judge_multi #(
        .N_LANES(NL), .WINDOW_CYCLES(WC), .CNT_W(8), .SCORE_W(SW), .MAX_MISSES(MM)
    ) dut (
        .clk(clk), .rst(rst), .freq(freq), .random(random), .switch(switch),
        .led(led), .busy(busy), .hit(hit), .miss(miss), .timeout(timeout),
        .hit_count(hit_count), .miss_count(miss_count), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          e_hit;
        logic          e_miss;
        logic          e_tmo;
        logic [SW-1:0] e_hc;
        logic [SW-1:0] e_mc;
        logic          e_go;
        logic [NL-1:0] e_led;
        int            e_cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_hits, m_misses;
    bit   m_over;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every hit/miss pulse must match the next expected round outcome
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (hit === 1'b1 || miss === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse hit=%b miss=%b timeout=%b expected none (cycle %0d)",
                         hit, miss, timeout, cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.e_cyc));
                chk("hit", 32'(hit), 32'(e.e_hit));
                chk("miss", 32'(miss), 32'(e.e_miss));
                chk("timeout", 32'(timeout), 32'(e.e_tmo));
                chk("hit_count", 32'(hit_count), 32'(e.e_hc));
                chk("miss_count", 32'(miss_count), 32'(e.e_mc));
                chk("game_over", 32'(game_over), 32'(e.e_go));
                chk("led_after", 32'(led), 32'(e.e_led));
                chk("busy_after", 32'(busy), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        freq = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {led, busy, hit, miss, timeout, hit_count, miss_count, game_over}, 32'd0);
        rst = 1'b0;
        m_hits = 0;
        m_misses = 0;
        m_over = 1'b0;
        q.delete();
    endtask

    // One round: target tgt, flip switches (0 = none) d negedges after freq is dropped
    task automatic round(input logic [NL-1:0] tgt, input logic [NL-1:0] flip, input int d);
        exp_t e;
        int   start;
        int   k;
        @(negedge clk);
        freq = 1'b1;
        random = tgt;
        @(negedge clk);
        start = cyc;
        freq = 1'b0;
        random = NL'($urandom);
        chk("led_active", 32'(led), 32'(tgt));
        chk("busy_active", 32'(busy), 32'd1);
        e.e_hit = 1'b0;
        e.e_miss = 1'b0;
        e.e_tmo = 1'b0;
        if (flip != 0 && d < int'(WC)) begin
            e.e_cyc = start + d + 1;
            if (flip == tgt) begin
                e.e_hit = 1'b1;
                if (m_hits < 255) m_hits++;
            end else begin
                e.e_miss = 1'b1;
            end
        end else begin
            e.e_cyc = start + int'(WC);
            e.e_miss = 1'b1;
            e.e_tmo = 1'b1;
        end
        if (e.e_miss) begin
            if (m_misses < 255) m_misses++;
            m_over = (m_misses == int'(MM));
        end
        e.e_hc = SW'(m_hits);
        e.e_mc = SW'(m_misses);
        e.e_go = m_over;
        e.e_led = m_over ? '1 : '0;
        q.push_back(e);
        for (k = 0; k < d; k++) @(negedge clk);
        if (flip != 0) switch = switch ^ flip;
        for (k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL round_timeout no pulse seen for target=%0h expected one", tgt);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Game-over lock: freq and switches ignored, LEDs all on
    task automatic over_checks();
        @(negedge clk);
        freq = 1'b1;
        random = 8'h5A;
        @(negedge clk);
        freq = 1'b0;
        switch = switch ^ 8'h5A;
        repeat (3) @(negedge clk);
        chk("over_led", 32'(led), 32'hFF);
        chk("over_busy", 32'(busy), 32'd0);
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_miss_count", 32'(miss_count), 32'(m_misses));
    endtask

    initial begin
        logic [NL-1:0] tgt;
        logic [NL-1:0] flip;
        int            d;
        rst = 1'b1;
        freq = 1'b0;
        random = '0;
        switch = '0;
        do_reset();

        round(8'h04, 8'h04, 5);
        chk("first_hit_count", 32'(hit_count), 32'd1);
        round(8'h04, 8'h20, 3);
        round(8'h10, 8'h00, 0);
        round(8'h04, 8'h04, 15);
        round(8'h03, 8'h01, 2);
        m_over = 1'b0;

        // Idle: zero pattern and stray switch flips start nothing
        do_reset();
        round(8'h81, 8'h81, 7);
        @(negedge clk);
        freq = 1'b1;
        random = 8'h00;
        @(negedge clk);
        freq = 1'b0;
        switch = switch ^ 8'hC3;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_led", 32'(led), 32'd0);
        chk("idle_counts", 32'({hit_count, miss_count}), 32'({SW'(m_hits), SW'(m_misses)}));

        round(8'h01, 8'h02, 0);
        round(8'h02, 8'h00, 0);
        round(8'h40, 8'h80, 1);
        chk("game_over_reached", 32'(game_over), 32'd1);
        over_checks();
        do_reset();

        for (int r = 0; r < 60; r++) begin
            tgt = NL'($urandom_range(1, 255));
            case ($urandom_range(0, 4))
                0, 1:    flip = tgt;
                2:       flip = NL'($urandom_range(1, 255));
                3:       flip = tgt ^ NL'(1 << $urandom_range(0, 7));
                default: flip = '0;
            endcase
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 13);
            round(tgt, flip, d);
            if (m_over) begin
                over_checks();
                do_reset();
            end
        end

        // Reset in the middle of an open round aborts silently
        @(negedge clk);
        freq = 1'b1;
        random = 8'h22;
        @(negedge clk);
        freq = 1'b0;
        repeat (3) @(negedge clk);
        chk("midround_busy", 32'(busy), 32'd1);
        do_reset();
        repeat (20) @(negedge clk);
        chk("post_reset_idle", {led, busy, hit_count, miss_count, game_over}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
